imem_boot_loader: RTL and testbench
===================================

# imem_boot_loader

Boot-time controller for the 1024 x 32 instruction memory. Receives a framed byte stream over a valid/ready link, assembles little-endian 32-bit words, writes them through the memory's write port, and verifies a checksum. Holds the CPU core in reset until a complete, verified image is in memory. Sits between the host/debug byte link and the instruction memory write port, and drives the core's reset input.

## Interface
- ADDR_W, 10: word-address width; capacity 2^ADDR_W words.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader can accept a byte.
- mem_we  output  1  instruction-memory write strobe, one cycle per word.
- mem_waddr  output  ADDR_W  word address of the write.
- mem_wdata  output  32  assembled word.
- cpu_reset  output  1  active-low reset to the core; 0 holds the core.
- busy  output  1  frame in progress, i.e. state in CNT_HI, DATA or CSUM.
- done  output  1  image loaded and checksum matched.
- err  output  1  frame rejected.

## Operation
- Frame format: count low byte, count high byte (N, word count), then 4N data bytes (each word LSB first), then 1 checksum byte equal to the sum of all 4N data bytes mod 256.
- Byte acceptance: rising clk with rx_valid & rx_ready.
- States:
  - CNT_LO: accept byte -> CNT_HI.
  - CNT_HI: accept byte -> DATA if 1 <= N <= 2^ADDR_W; otherwise -> ERR.
  - DATA: after byte 4N is accepted -> CSUM.
  - CSUM: accept byte; match -> RUN, mismatch -> ERR.
  - RUN and ERR: an accepted byte is taken as the count low byte of a new frame -> CNT_HI.
- DATA byte k of a word (k = 0..3) goes to bits [8k+7:8k]. The byte counter and word index reset to 0 on entry to DATA.
- On acceptance of byte 3 of a word:
  - mem_wdata and mem_waddr (word index) are registered.
  - mem_we is high for exactly the next cycle.
  - The word index increments.
- The checksum accumulator is 8 bits, wraps mod 256, and clears on entry to CNT_LO/CNT_HI of a new frame.
- rx_ready is 1 in all states, except 0 during any cycle in which mem_we is 1 (one-cycle stall per word).
- cpu_reset is 1 only in RUN.
- done is 1 only in RUN. err is 1 only in ERR.
- Words beyond N in memory are not touched.

## Timing
- Async reset (reset = 0) forces:
  - state = CNT_LO; counters and checksum = 0.
  - mem_we = 0, mem_waddr = 0, mem_wdata = 0.
  - rx_ready = 1, cpu_reset = 0, busy = 0, done = 0, err = 0.
- Reset mid-frame aborts immediately; the partial image is left in memory and the core stays held.
- Write latency: mem_we is asserted 1 cycle after acceptance of a word's last byte.
- The checksum byte accepted at edge t gives state/done/err/cpu_reset updated at edge t (visible in cycle t+1).
- A new frame byte accepted in RUN drops cpu_reset and done in the following cycle.
- Minimum frame duration with back-to-back valid bytes: 2 + 5N + 1 cycles (the stall adds 1 cycle per word).
- rx_valid with rx_ready = 0: the byte is not consumed, and the sender must hold rx_data until accepted.
- N = 2^ADDR_W: the final word is written at address 2^ADDR_W - 1, and the index wraps to 0 only after the write, unused.

## Test plan
- Reset release, idle link -> cpu_reset = 0, done = 0, err = 0, rx_ready = 1, mem_we never pulses.
- Frame 04 00, 93 02 20 00, 13 03 00 04, 23 24 53 00, 83 23 83 00, 92, sent back-to-back:
  - Expect 4 mem_we pulses: (0, 0x00200293), (1, 0x04000313), (2, 0x00532423), (3, 0x00832383).
  - Expect rx_ready low on each pulse cycle.
  - Then done = 1 and cpu_reset = 1.
- Same frame with checksum 0x93 -> 4 writes occur, then err = 1, cpu_reset = 0, done = 0.
- Count 00 00 -> ERR directly after the second byte, no writes. A following valid frame of N = 1 (words 0x00000013, checksum 0x13) -> done = 1.
- Reset asserted after 6 data bytes of the 4-word frame -> immediate return to reset values. A subsequent full frame loads correctly from address 0.
- While in RUN, send a 1-word frame (01 00, FF FF FF FF, FC):
  - cpu_reset drops to 0 the cycle after the first byte.
  - Write (0, 0xFFFFFFFF) occurs.
  - done and cpu_reset return to 1.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Boot loader: framed byte stream -> 32-bit instruction memory words.
// Holds the core in reset until a checksum-verified image is loaded.
module imem_boot_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_CNT_LO,
        S_CNT_HI,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    localparam int unsigned MAXN = 1 << ADDR_W;

    state_t              r_state;
    logic [7:0]          r_cnt_lo;
    logic [ADDR_W:0]     r_left;
    logic [ADDR_W-1:0]   r_widx;
    logic [1:0]          r_byte;
    logic [23:0]         r_wbuf;
    logic [7:0]          r_sum;
    logic                r_we;
    logic [ADDR_W-1:0]   r_waddr;
    logic [31:0]         r_wdata;

    logic                w_acc;
    logic [15:0]         w_n;
    logic                w_n_ok;
    logic [ADDR_W:0]     w_left_init;

    assign w_acc       = rx_valid & rx_ready;
    assign w_n         = {rx_data, r_cnt_lo};
    assign w_n_ok      = (w_n != 16'd0) && (32'(w_n) <= MAXN);
    assign w_left_init = (ADDR_W+1)'(w_n);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_CNT_LO;
            r_cnt_lo <= 8'd0;
            r_left   <= '0;
            r_widx   <= '0;
            r_byte   <= 2'd0;
            r_wbuf   <= 24'd0;
            r_sum    <= 8'd0;
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= 32'd0;
        end else begin
            r_we <= 1'b0;
            if (w_acc) begin
                unique case (r_state)
                    S_CNT_LO, S_RUN, S_ERR: begin
                        r_cnt_lo <= rx_data;
                        r_sum    <= 8'd0;
                        r_state  <= S_CNT_HI;
                    end
                    S_CNT_HI: begin
                        if (w_n_ok) begin
                            r_left  <= w_left_init;
                            r_widx  <= '0;
                            r_byte  <= 2'd0;
                            r_state <= S_DATA;
                        end else begin
                            r_state <= S_ERR;
                        end
                    end
                    S_DATA: begin
                        r_sum  <= r_sum + rx_data;
                        r_byte <= r_byte + 2'd1;
                        unique case (r_byte)
                            2'd0: r_wbuf[7:0]   <= rx_data;
                            2'd1: r_wbuf[15:8]  <= rx_data;
                            2'd2: r_wbuf[23:16] <= rx_data;
                            2'd3: begin
                                r_wdata <= {rx_data, r_wbuf};
                                r_waddr <= r_widx;
                                r_we    <= 1'b1;
                                r_widx  <= r_widx + ADDR_W'(1);
                                r_left  <= r_left - (ADDR_W+1)'(1);
                                if (r_left == (ADDR_W+1)'(1))
                                    r_state <= S_CSUM;
                            end
                        endcase
                    end
                    S_CSUM: begin
                        r_state <= (rx_data == r_sum) ? S_RUN : S_ERR;
                    end
                    default: r_state <= S_CNT_LO;
                endcase
            end
        end
    end

    // The write cycle doubles as the one-cycle stall on the byte link.
    assign rx_ready  = ~r_we;
    assign mem_we    = r_we;
    assign mem_waddr = r_waddr;
    assign mem_wdata = r_wdata;
    assign cpu_reset = (r_state == S_RUN);
    assign done      = (r_state == S_RUN);
    assign err       = (r_state == S_ERR);
    assign busy      = (r_state == S_CNT_HI) || (r_state == S_DATA) ||
                       (r_state == S_CSUM);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: directed frames plus random frames
// checked against a frame-level model of writes and final status.
module tb_imem_boot_loader;

    localparam int AW = 10;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic          cpu_reset;
    logic          busy;
    logic          done;
    logic          err;

    int  total = 0;
    int  bad   = 0;
    int  edges = 0;
    int  viol  = 0;
    wr_t wq[$];
    wr_t exp_q[$];

    imem_boot_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset === 1'b1 && mem_we === 1'b1) begin
            wq.push_back({mem_waddr, mem_wdata});
            if (rx_ready !== 1'b0) viol++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit acc = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int t = 0; t < 4 && !acc; t++) begin
            acc = (rx_ready === 1'b1);
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        total++;
        if (!acc) begin
            bad++;
            $display("FAIL accept_timeout byte=%h got=not_accepted exp=accepted", b);
        end
    endtask

    task automatic send_frame(input bq_t f, input int gap);
        foreach (f[i]) begin
            send_byte(f[i]);
            if (gap > 0) repeat ($urandom_range(0, gap)) @(negedge clk);
        end
    endtask

    function automatic bq_t build(input logic [31:0] w[$], input int n,
                                  input bit badcs);
        bq_t f;
        logic [7:0] s = 8'd0;
        f.push_back(n[7:0]);
        f.push_back(n[15:8]);
        if (n < 1 || n > (1 << AW)) return f;
        foreach (w[i]) begin
            for (int k = 0; k < 4; k++) begin
                logic [7:0] b;
                b = w[i][8*k +: 8];
                f.push_back(b);
                s = s + b;
            end
        end
        f.push_back(badcs ? s + 8'd1 : s);
        return f;
    endfunction

    function automatic bq_t spec_frame();
        bq_t f;
        f = '{8'h04, 8'h00, 8'h93, 8'h02, 8'h20, 8'h00, 8'h13, 8'h03,
              8'h00, 8'h04, 8'h23, 8'h24, 8'h53, 8'h00, 8'h83, 8'h23,
              8'h83, 8'h00, 8'h92};
        return f;
    endfunction

    task automatic spec_writes();
        exp_q.delete();
        exp_q.push_back({10'd0, 32'h00200293});
        exp_q.push_back({10'd1, 32'h04000313});
        exp_q.push_back({10'd2, 32'h00532423});
        exp_q.push_back({10'd3, 32'h00832383});
    endtask

    task automatic test_reset();
        logic [47:0] got;
        logic [47:0] want;
        want     = {1'b0, 10'd0, 32'd0, 1'b1, 4'b0000};
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        got = {mem_we, mem_waddr, mem_wdata, rx_ready, cpu_reset, busy, done, err};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL reset_values got=%h exp=%h", got, want);
        end
        reset = 1'b1;
        repeat (10) @(negedge clk);
        got = {mem_we, mem_waddr, mem_wdata, rx_ready, cpu_reset, busy, done, err};
        total++;
        if (got !== want || wq.size() != 0) begin
            bad++;
            $display("FAIL idle_after_reset got=%h writes=%0d exp=%h writes=0",
                     got, wq.size(), want);
        end
    endtask

    task automatic test_spec_frame(input bit badcs);
        bq_t f;
        logic [3:0] st;
        logic [3:0] want;
        f = spec_frame();
        if (badcs) f[18] = 8'h93;
        spec_writes();
        wq.delete();
        edges = 0;
        viol  = 0;
        send_frame(f, 0);
        st   = {done, err, cpu_reset, busy};
        want = badcs ? 4'b0100 : 4'b1010;
        total++;
        if (st !== want) begin
            bad++;
            $display("FAIL spec_status bad=%0d got=%b exp=%b", badcs, st, want);
        end
        total++;
        if (edges != 2 + 5 * 4 + 1) begin
            bad++;
            $display("FAIL spec_cycles got=%0d exp=%0d", edges, 23);
        end
        repeat (2) @(negedge clk);
        total++;
        if (viol != 0) begin
            bad++;
            $display("FAIL ready_on_write got=%0d exp=0", viol);
        end
        total++;
        if (wq.size() != exp_q.size()) begin
            bad++;
            $display("FAIL spec_wr_count got=%0d exp=%0d", wq.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < wq.size()) begin
            total++;
            if (wq[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL spec_wr[%0d] got=%h exp=%h", i, wq[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_zero_count();
        bq_t f;
        wq.delete();
        send_byte(8'h00);
        send_byte(8'h00);
        total++;
        if ({err, busy, done} !== 3'b100) begin
            bad++;
            $display("FAIL zero_count got=%b exp=100", {err, busy, done});
        end
        f = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        send_frame(f, 0);
        repeat (2) @(negedge clk);
        total++;
        if ({done, err, cpu_reset} !== 3'b101) begin
            bad++;
            $display("FAIL after_zero got=%b exp=101", {done, err, cpu_reset});
        end
        total++;
        if (wq.size() != 1 || wq[0] !== {10'd0, 32'h00000013}) begin
            bad++;
            $display("FAIL after_zero_wr got=%0d writes exp=1 write (0,00000013)",
                     wq.size());
        end
    endtask

    task automatic test_reset_mid();
        bq_t f;
        logic [47:0] got;
        logic [47:0] want;
        want = {1'b0, 10'd0, 32'd0, 1'b1, 4'b0000};
        f = spec_frame();
        for (int i = 0; i < 8; i++) send_byte(f[i]);
        #2 reset = 1'b0;
        #1;
        got = {mem_we, mem_waddr, mem_wdata, rx_ready, cpu_reset, busy, done, err};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL mid_reset got=%h exp=%h", got, want);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        wq.delete();
        spec_writes();
        send_frame(f, 0);
        repeat (2) @(negedge clk);
        total++;
        if ({done, cpu_reset} !== 2'b11) begin
            bad++;
            $display("FAIL reload_status got=%b exp=11", {done, cpu_reset});
        end
        total++;
        if (wq.size() != exp_q.size()) begin
            bad++;
            $display("FAIL reload_wr_count got=%0d exp=%0d", wq.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < wq.size()) begin
            total++;
            if (wq[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL reload_wr[%0d] got=%h exp=%h", i, wq[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_run_reload();
        bq_t f;
        f = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC};
        wq.delete();
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL run_entry got=%b exp=1", done);
        end
        send_byte(8'h01);
        total++;
        if ({cpu_reset, done, busy} !== 3'b001) begin
            bad++;
            $display("FAIL run_drop got=%b exp=001", {cpu_reset, done, busy});
        end
        send_frame(f, 0);
        repeat (2) @(negedge clk);
        total++;
        if ({done, cpu_reset} !== 2'b11) begin
            bad++;
            $display("FAIL run_back got=%b exp=11", {done, cpu_reset});
        end
        total++;
        if (wq.size() != 1 || wq[0] !== {10'd0, 32'hFFFFFFFF}) begin
            bad++;
            $display("FAIL run_wr got=%0d writes exp=1 write (0,ffffffff)", wq.size());
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            logic [31:0] w[$];
            bq_t f;
            int n;
            bit badcs;
            bit ok;
            logic [3:0] want;
            if ($urandom_range(0, 7) == 0)
                n = $urandom_range(0, 1) ? 0 : $urandom_range(1025, 65535);
            else
                n = $urandom_range(1, 8);
            badcs = ($urandom_range(0, 3) == 0);
            ok    = (n >= 1 && n <= (1 << AW));
            exp_q.delete();
            if (ok) begin
                for (int i = 0; i < n; i++) begin
                    w.push_back($urandom);
                    exp_q.push_back({AW'(i), w[i]});
                end
            end
            f = build(w, n, badcs);
            wq.delete();
            viol = 0;
            send_frame(f, 2);
            repeat (2) @(negedge clk);
            want = (ok && !badcs) ? 4'b1010 : 4'b0100;
            total++;
            if ({done, err, cpu_reset, busy} !== want || viol != 0) begin
                bad++;
                $display("FAIL rand%0d_status n=%0d got=%b viol=%0d exp=%b viol=0",
                         it, n, {done, err, cpu_reset, busy}, viol, want);
            end
            total++;
            if (wq.size() != exp_q.size()) begin
                bad++;
                $display("FAIL rand%0d_wr_count got=%0d exp=%0d",
                         it, wq.size(), exp_q.size());
            end
            foreach (exp_q[i]) if (i < wq.size()) begin
                total++;
                if (wq[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL rand%0d_wr[%0d] got=%h exp=%h",
                             it, i, wq[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_max();
        logic [31:0] w[$];
        bq_t f;
        int n;
        n = 1 << AW;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            w.push_back($urandom);
            exp_q.push_back({AW'(i), w[i]});
        end
        f = build(w, n, 1'b0);
        wq.delete();
        edges = 0;
        send_frame(f, 0);
        total++;
        if (edges != 2 + 5 * n + 1) begin
            bad++;
            $display("FAIL max_cycles got=%0d exp=%0d", edges, 2 + 5 * n + 1);
        end
        repeat (2) @(negedge clk);
        total++;
        if ({done, err} !== 2'b10 || wq.size() != n) begin
            bad++;
            $display("FAIL max_status got=%b writes=%0d exp=10 writes=%0d",
                     {done, err}, wq.size(), n);
        end
        foreach (exp_q[i]) if (i < wq.size()) begin
            total++;
            if (wq[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL max_wr[%0d] got=%h exp=%h", i, wq[i], exp_q[i]);
            end
        end
        wq.delete();
        send_byte(8'h01);
        send_byte(8'h04);
        repeat (2) @(negedge clk);
        total++;
        if ({err, done} !== 2'b10 || wq.size() != 0) begin
            bad++;
            $display("FAIL over_max got=%b writes=%0d exp=10 writes=0",
                     {err, done}, wq.size());
        end
    endtask

    initial begin
        test_reset();
        test_spec_frame(1'b0);
        test_spec_frame(1'b1);
        test_zero_count();
        test_reset_mid();
        test_run_reload();
        test_random();
        test_max();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
